fp_arb_sched: RTL and testbench
===============================

Name: fp_arb_sched

Overview:
- Round-robin scheduler that shares one fp_13 add/sub pipeline between NREQ requesters.
- Arbitrates one request per cycle and drives the operands into the adder.
- Carries the winner's ID alongside the operation through a tag pipeline of depth LAT, then returns the adder result as a registered pulse to that requester only.
- Owns all validity tracking, because the adder's internal flag registers are not reset.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 2, adder latency in cycles from operands applied to c valid (fp_13 = 2).
- IDW, $clog2(NREQ), width of the requester tag.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_en  in  1  1 = arbitration enabled; 0 = no new grants, in-flight ops still complete.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant (one-hot or zero).
- req_op  in  NREQ  per-requester op (0 add, 1 subtract).
- req_a  in  NREQ*32  packed Float32 operand a, requester i at [32i+:32].
- req_b  in  NREQ*32  packed Float32 operand b.
- fpu_flag  out  1  issue strobe to adder flag_i.
- fpu_op  out  1  op to adder.
- fpu_a  out  32  operand a to adder.
- fpu_b  out  32  operand b to adder.
- fpu_c  in  32  adder result c.
- resp_valid  out  NREQ  one-hot, one-cycle result pulse.
- resp_c  out  32  result, shared by all requesters, qualified by resp_valid.
- busy  out  1  1 while any op is in flight.

Behaviour:
- Reset (rst=0, async): rr_ptr=NREQ-1, tag pipeline valid bits=0, resp_valid=0, resp_c=0, inflight=0. Combinational outputs are then req_ready=0, fpu_flag=0, fpu_a/b/op=0, busy=0.
- Grant (combinational):
  - When issue_en=1, the first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ, gets req_ready[i]=1.
  - At most one ready bit is set. req_ready depends on req_valid.
  - Requesters must hold valid and data stable until ready is seen.
- Issue: a handshake in cycle t (valid&ready) drives fpu_flag=1 and fpu_a/b/op = the winner's fields in the same cycle t. With no grant, fpu_flag=0 and fpu_a/b/op=0.
- rr_ptr updates to the winner index on each issue and is unchanged otherwise. Wrap from NREQ-1 to 0.
- Tag pipeline: LAT stages of {valid, id}. Stage 0 captures {issue, winner} on each edge; stage k captures stage k-1.
- Response: on each edge, if the last tag stage is valid, resp_valid[id]<=1 and resp_c<=fpu_c; otherwise resp_valid<=0 and resp_c holds its value.
- Latency: a handshake in cycle t gives resp_valid in cycle t+LAT+1. Throughput is 1 op/cycle, with no bubbles under continuous requests.
- No response backpressure: a requester must accept its pulse.
- inflight counter (width clog2(LAT+2)): +1 on issue, -1 on resp_valid pulse, both in the same cycle gives no change. Never exceeds LAT+1. busy = (inflight != 0).
- issue_en falling mid-stream: ops already granted complete normally. rr_ptr is frozen.
- Reset asserted mid-operation:
  - All in-flight ops are discarded and no resp_valid is emitted for them.
  - fpu_c values from pre-reset ops are ignored because the tags are cleared.
- The adder's flag_o is unused.
- A requester may have several ops in flight. Responses return in issue order.

Decomposition:
- Package definitions: reuse Float32, and add the typedef FpTag {logic valid; logic [IDW-1:0] id;} and the constant FP_ADD_LAT=2 (default for LAT).
- Sub-module rr_arbiter (NREQ): inputs req, en, ptr; output one-hot grant plus encoded index. It is pure combinational, and rr_ptr is owned by fp_arb_sched.
- The tag pipeline, response register and counter stay in the top.

Test Plan:
- Single request: req 1 issued alone with a=0x3F800000, b=0x40000000, op=0 -> fpu_flag in cycle t; resp_valid=0b0010, resp_c=0x40400000 in t+3; busy 1 for cycles t+1..t+3.
- Simultaneous req 0 and req 2 after reset -> grant 0 then 2 in consecutive cycles. Responses in the same order, 1 cycle apart; second op a=0x40400000, b=0x3F800000, op=1 gives resp_c=0x40000000.
- All four valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3, fpu_flag=1 every cycle, eight resp pulses in matching order.
- issue_en=0 with req 3 valid for 5 cycles -> req_ready=0 and fpu_flag=0 throughout; in-flight ops still return. Raising issue_en gives req 3 ready the same cycle.
- rst pulled low 1 cycle after two issues -> no resp_valid afterwards, busy=0, inflight=0. The next request after release is granted to req 0.
- Back-to-back same requester: req 1 alone, valid 3 cycles -> 3 issues, inflight peaks at 3, resp_valid[1] pulses 3 consecutive cycles.

Source files
------------

// File: rtl/fp_arb_sched_pkg.sv
// rtl/fp_arb_sched_pkg.sv - shared types and constants for the fp_13 arbiter/scheduler
// Tag ids are sized for the largest supported requester count (8).
package fp_arb_sched_pkg;

  typedef logic [31:0] Float32;

  localparam int FP_ADD_LAT = 2;
  localparam int FP_TAG_IDW = 3;

  typedef struct packed {
    logic                  valid;
    logic [FP_TAG_IDW-1:0] id;
  } FpTag;

  function automatic FpTag fp_tag_make(input logic valid, input int idx);
    FpTag t;
    t.valid = valid;
    t.id    = FP_TAG_IDW'(idx);
    return t;
  endfunction

endpackage

// File: rtl/fp_arb_sched_rr_arbiter.sv
// rtl/fp_arb_sched_rr_arbiter.sv - combinational round-robin arbiter
// Searches ptr+1, ptr+2, ... modulo NREQ; the pointer register lives in the parent.
module fp_arb_sched_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_i;
    logic           found;
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    cand_i = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_i = IDW'(cand);
      if (en && !found && req[cand_i]) begin
        found         = 1'b1;
        grant[cand_i] = 1'b1;
        idx           = cand_i;
      end
    end
  end

endmodule

// File: rtl/fp_arb_sched.sv
// rtl/fp_arb_sched.sv - round-robin scheduler sharing one fp_13 add/sub pipeline
// The adder's own flags are unreset, so validity is tracked here by a tag pipeline.
module fp_arb_sched
  import fp_arb_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = FP_ADD_LAT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_en,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ-1:0]  req_op,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic             fpu_flag,
  output logic             fpu_op,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      fpu_c,
  output logic [NREQ-1:0]  resp_valid,
  output logic [31:0]      resp_c,
  output logic             busy
);

  localparam int CW = $clog2(LAT + 2);

  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_idx;
  logic            issue;
  FpTag            tag_q [LAT];
  logic [NREQ-1:0] resp_dec;
  logic            resp_pulse;
  logic [CW-1:0]   inflight;
  Float32          sel_a;
  Float32          sel_b;

  // Grants are held off while reset is asserted so nothing issues into a cleared pipe.
  fp_arb_sched_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (req_valid),
    .en    (issue_en && rst),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (win_idx)
  );

  assign req_ready = grant;
  assign issue     = |grant;
  assign fpu_flag  = issue;

  always_comb begin
    sel_a  = req_a[int'(win_idx)*32 +: 32];
    sel_b  = req_b[int'(win_idx)*32 +: 32];
    fpu_a  = '0;
    fpu_b  = '0;
    fpu_op = 1'b0;
    if (issue) begin
      fpu_a  = sel_a;
      fpu_b  = sel_b;
      fpu_op = req_op[win_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= IDW'(NREQ - 1);
    end else if (issue) begin
      rr_ptr <= win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= fp_tag_make(issue, int'(win_idx));
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  always_comb begin
    resp_dec = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_dec[i] = (tag_q[LAT-1].id == FP_TAG_IDW'(i));
    end
  end

  // resp_c holds the last result between pulses; only resp_valid returns to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= '0;
      resp_c     <= '0;
    end else if (tag_q[LAT-1].valid) begin
      resp_valid <= resp_dec;
      resp_c     <= fpu_c;
    end else begin
      resp_valid <= '0;
    end
  end

  assign resp_pulse = |resp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
    end else begin
      case ({issue, resp_pulse})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != '0);

endmodule

// File: tb/tb_fp_arb_sched.sv
// tb/tb_fp_arb_sched.sv - self-checking bench for fp_arb_sched
// Row table of per-cycle stimulus/expectations plus hand sequences for reset and wrap.
module tb_fp_arb_sched;
  import fp_arb_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam logic [31:0] C0 = 32'h0000_0110;
  localparam logic [31:0] C1 = 32'h4040_0000;
  localparam logic [31:0] C2 = 32'h4000_0000;
  localparam logic [31:0] C3 = 32'h0000_02D0;

  logic               clk;
  logic               rst;
  logic               issue_en;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_op;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               fpu_flag;
  logic               fpu_op;
  logic [31:0]        fpu_a;
  logic [31:0]        fpu_b;
  logic [31:0]        fpu_c;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_c;
  logic               busy;

  logic [31:0] a_tab [NREQ];
  logic [31:0] b_tab [NREQ];
  logic        op_tab [NREQ];

  int checks;
  int failures;

  fp_arb_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .fpu_flag   (fpu_flag),
    .fpu_op     (fpu_op),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_c      (fpu_c),
    .resp_valid (resp_valid),
    .resp_c     (resp_c),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle adder stand-in: exact results for the float pairs used, integer math otherwise.
  function automatic logic [31:0] stub_add(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'h3F80_0000 && op)  return 32'h4000_0000;
    return op ? a - b : a + b;
  endfunction

  logic [31:0] add_s1;
  logic [31:0] add_c;
  always @(posedge clk) begin
    add_s1 <= stub_add(fpu_a, fpu_b, fpu_op);
    add_c  <= add_s1;
  end
  assign fpu_c = add_c;

  typedef struct {
    bit          rst;
    bit          en;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [3:0]  resp;
    logic [31:0] c;
    int          infl;
  } vec_t;

  localparam int NV = 54;
  vec_t vt [NV];

  function automatic vec_t mk(input bit r, input bit e, input logic [3:0] v, input logic [3:0] rd,
                              input logic [3:0] rs, input logic [31:0] c, input int n);
    vec_t x;
    x.rst = r; x.en = e; x.valid = v; x.ready = rd; x.resp = rs; x.c = c; x.infl = n;
    return x;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=0x%08h want=0x%08h", name, row, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea, eb;
    logic        eo;
    int          n;
    checks   = 0;
    failures = 0;

    a_tab[0] = 32'h0000_0100; b_tab[0] = 32'h0000_0010; op_tab[0] = 1'b0;
    a_tab[1] = 32'h3F80_0000; b_tab[1] = 32'h4000_0000; op_tab[1] = 1'b0;
    a_tab[2] = 32'h4040_0000; b_tab[2] = 32'h3F80_0000; op_tab[2] = 1'b1;
    a_tab[3] = 32'h0000_0300; b_tab[3] = 32'h0000_0030; op_tab[3] = 1'b1;
    req_a  = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
    req_b  = {b_tab[3], b_tab[2], b_tab[1], b_tab[0]};
    req_op = {op_tab[3], op_tab[2], op_tab[1], op_tab[0]};

    // single request, req 1
    vt[0]  = mk(1,1,4'b0000,4'b0000,4'b0000,32'h0,0);
    vt[1]  = mk(1,1,4'b0010,4'b0010,4'b0000,32'h0,0);
    vt[2]  = mk(1,1,4'b0000,4'b0000,4'b0000,32'h0,1);
    vt[3]  = mk(1,1,4'b0000,4'b0000,4'b0000,32'h0,1);
    vt[4]  = mk(1,1,4'b0000,4'b0000,4'b0010,C1,1);
    vt[5]  = mk(1,1,4'b0000,4'b0000,4'b0000,C1,0);
    // reset, then req 0 and req 2 together
    vt[6]  = mk(0,1,4'b0000,4'b0000,4'b0000,32'h0,0);
    vt[7]  = mk(1,1,4'b0101,4'b0001,4'b0000,32'h0,0);
    vt[8]  = mk(1,1,4'b0100,4'b0100,4'b0000,32'h0,1);
    vt[9]  = mk(1,1,4'b0000,4'b0000,4'b0000,32'h0,2);
    vt[10] = mk(1,1,4'b0000,4'b0000,4'b0001,C0,2);
    vt[11] = mk(1,1,4'b0000,4'b0000,4'b0100,C2,1);
    vt[12] = mk(1,1,4'b0000,4'b0000,4'b0000,C2,0);
    // reset, then all four continuously for 8 cycles
    vt[13] = mk(0,1,4'b0000,4'b0000,4'b0000,32'h0,0);
    vt[14] = mk(1,1,4'b1111,4'b0001,4'b0000,32'h0,0);
    vt[15] = mk(1,1,4'b1111,4'b0010,4'b0000,32'h0,1);
    vt[16] = mk(1,1,4'b1111,4'b0100,4'b0000,32'h0,2);
    vt[17] = mk(1,1,4'b1111,4'b1000,4'b0001,C0,3);
    vt[18] = mk(1,1,4'b1111,4'b0001,4'b0010,C1,3);
    vt[19] = mk(1,1,4'b1111,4'b0010,4'b0100,C2,3);
    vt[20] = mk(1,1,4'b1111,4'b0100,4'b1000,C3,3);
    vt[21] = mk(1,1,4'b1111,4'b1000,4'b0001,C0,3);
    vt[22] = mk(1,1,4'b0000,4'b0000,4'b0010,C1,3);
    vt[23] = mk(1,1,4'b0000,4'b0000,4'b0100,C2,2);
    vt[24] = mk(1,1,4'b0000,4'b0000,4'b1000,C3,1);
    vt[25] = mk(1,1,4'b0000,4'b0000,4'b0000,C3,0);
    // one op in flight, then issue_en low with req 3 waiting
    vt[26] = mk(1,1,4'b0001,4'b0001,4'b0000,C3,0);
    vt[27] = mk(1,0,4'b1000,4'b0000,4'b0000,C3,1);
    vt[28] = mk(1,0,4'b1000,4'b0000,4'b0000,C3,1);
    vt[29] = mk(1,0,4'b1000,4'b0000,4'b0001,C0,1);
    vt[30] = mk(1,0,4'b1000,4'b0000,4'b0000,C0,0);
    vt[31] = mk(1,0,4'b1000,4'b0000,4'b0000,C0,0);
    vt[32] = mk(1,1,4'b1000,4'b1000,4'b0000,C0,0);
    vt[33] = mk(1,1,4'b0000,4'b0000,4'b0000,C0,1);
    vt[34] = mk(1,1,4'b0000,4'b0000,4'b0000,C0,1);
    vt[35] = mk(1,1,4'b0000,4'b0000,4'b1000,C3,1);
    vt[36] = mk(1,1,4'b0000,4'b0000,4'b0000,C3,0);
    // back-to-back req 1
    vt[37] = mk(1,1,4'b0010,4'b0010,4'b0000,C3,0);
    vt[38] = mk(1,1,4'b0010,4'b0010,4'b0000,C3,1);
    vt[39] = mk(1,1,4'b0010,4'b0010,4'b0000,C3,2);
    vt[40] = mk(1,1,4'b0000,4'b0000,4'b0010,C1,3);
    vt[41] = mk(1,1,4'b0000,4'b0000,4'b0010,C1,2);
    vt[42] = mk(1,1,4'b0000,4'b0000,4'b0010,C1,1);
    vt[43] = mk(1,1,4'b0000,4'b0000,4'b0000,C1,0);
    // reset one cycle after two issues
    vt[44] = mk(1,1,4'b0010,4'b0010,4'b0000,C1,0);
    vt[45] = mk(1,1,4'b0100,4'b0100,4'b0000,C1,1);
    vt[46] = mk(0,1,4'b0000,4'b0000,4'b0000,32'h0,0);
    vt[47] = mk(1,1,4'b0000,4'b0000,4'b0000,32'h0,0);
    vt[48] = mk(1,1,4'b0000,4'b0000,4'b0000,32'h0,0);
    vt[49] = mk(1,1,4'b1111,4'b0001,4'b0000,32'h0,0);
    vt[50] = mk(1,1,4'b0000,4'b0000,4'b0000,32'h0,1);
    vt[51] = mk(1,1,4'b0000,4'b0000,4'b0000,32'h0,1);
    vt[52] = mk(1,1,4'b0000,4'b0000,4'b0001,C0,1);
    vt[53] = mk(1,1,4'b0000,4'b0000,4'b0000,C0,0);

    rst = 1'b0; issue_en = 1'b0; req_valid = '0;
    repeat (3) @(negedge clk);

    for (int r = 0; r < NV; r++) begin
      @(negedge clk);
      rst       = vt[r].rst;
      issue_en  = vt[r].en;
      req_valid = vt[r].valid;
      #3;
      ea = '0; eb = '0; eo = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (vt[r].ready[i]) begin
          ea = a_tab[i]; eb = b_tab[i]; eo = op_tab[i];
        end
      end
      chk("req_ready",  r, 32'(req_ready),  32'(vt[r].ready));
      chk("fpu_flag",   r, 32'(fpu_flag),   32'(vt[r].ready != 4'b0000));
      chk("fpu_a",      r, fpu_a,           ea);
      chk("fpu_b",      r, fpu_b,           eb);
      chk("fpu_op",     r, 32'(fpu_op),     32'(eo));
      chk("resp_valid", r, 32'(resp_valid), 32'(vt[r].resp));
      chk("resp_c",     r, resp_c,          vt[r].c);
      chk("inflight",   r, 32'(dut.inflight), 32'(vt[r].infl));
      chk("busy",       r, 32'(busy),       32'(vt[r].infl != 0));
    end

    // async reset landing on a response pulse cancels it at once
    @(negedge clk);
    rst = 1'b1; issue_en = 1'b1; req_valid = 4'b0100;
    #3 chk("seqA_grant", 100, 32'(req_ready), 32'h4);
    n = 0;
    do begin
      @(negedge clk);
      req_valid = '0;
      #3;
      n++;
    end while (resp_valid == '0 && n < 8);
    chk("seqA_latency", 101, 32'(n), 32'(LAT + 1));
    chk("seqA_resp",    102, 32'(resp_valid), 32'h4);
    chk("seqA_c",       103, resp_c, C2);
    rst = 1'b0;
    #1;
    chk("seqA_rst_resp", 104, 32'(resp_valid), 32'h0);
    chk("seqA_rst_c",    105, resp_c, 32'h0);
    chk("seqA_rst_busy", 106, 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #3 chk("seqA_quiet", 107 + k, 32'(resp_valid), 32'h0);
    end

    // pointer wrap: req 3 wins from reset pointer, then req 0 wins over req 3
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b1000;
    #3 chk("seqB_grant3", 110, 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b1001;
    #3 chk("seqB_grant0", 111, 32'(req_ready), 32'h1);
    n = 0;
    do begin
      @(negedge clk);
      req_valid = '0;
      #3;
      n++;
    end while (resp_valid == '0 && n < 8);
    chk("seqB_resp1", 112, 32'(resp_valid), 32'h8);
    chk("seqB_c1",    113, resp_c, C3);
    @(negedge clk);
    #3;
    chk("seqB_resp2", 114, 32'(resp_valid), 32'h1);
    chk("seqB_c2",    115, resp_c, C0);
    @(negedge clk);
    #3 chk("seqB_idle", 116, 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
